neuronunit_seq: RTL and testbench
=================================

// Module: neuronunit_seq
// PURPOSE
//  Sequencer for one neuronunit. Accepts parameter-load and sample requests over valid/ready, then drives
//  the unit's strobes in order: ini_para, en_input, en_renew, en_divide. Waits for divider completion,
//  captures dist/norm_dist and returns them over a valid/ready result port. Sits between the node scheduler
//  and a single neuronunit instance; the scheduler never touches neuronunit strobes directly.
// PARAMETERS
//  DW          16   data width of in/mu/sigma2/dist/norm_dist (signed Q1.14)
//  INIT_CYC    2    cycles ini_para is held high with mu/sigma2 stable
//  DIV_TMO     32   max cycles in WAIT_DIV before forced completion (divider needs >=14)
//  CNT_W       16   width of processed-sample counter
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous, active-low reset
//  cfg_valid      in   1       parameter-load request
//  cfg_mu         in   DW      initial mu
//  cfg_sigma2     in   DW      initial sigma2
//  cfg_ready      out  1       high in IDLE only
//  smp_valid      in   1       sample request
//  smp_data       in   DW      sample value
//  smp_learn      in   1       1 = update mu/sigma2 (renew_flag), 0 = distance only
//  smp_ready      out  1       high in IDLE only
//  res_valid      out  1       result available
//  res_dist       out  DW      captured nu_dist
//  res_norm_dist  out  DW      captured nu_norm_dist
//  res_ready      in   1       consumer accepts result
//  busy           out  1       state != IDLE
//  tmo_err        out  1       sticky: a divide timed out; cleared only by reset
//  smp_count      out  CNT_W   samples completed, wraps modulo 2^CNT_W
//  nu_in, nu_mu_ini, nu_sigma2_ini  out DW   registered operands to neuronunit
//  nu_ini_para, nu_en_input, nu_en_renew, nu_en_divide, nu_renew_flag  out 1   neuronunit strobes/mode
//  nu_dist, nu_norm_dist   in  DW   neuronunit results
//  nu_divider_flag         in  1    neuronunit divider done (level)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; all outputs 0 except cfg_ready=smp_ready=1; captured regs, counters 0.
//  All outputs registered. A request is accepted on the edge where valid&ready. cfg wins if both valid
//  in the same cycle; the sample stays pending (ready drops, valid must be held).
//  States:
//   IDLE     -> INIT on cfg accept (latch mu/sigma2); -> LOAD on smp accept (latch data, learn)
//   INIT     nu_ini_para=1, nu_mu_ini/nu_sigma2_ini=latched, INIT_CYC cycles; then operands zeroed, -> IDLE
//   LOAD     nu_in=latched data (held until next sample), nu_renew_flag=learn (held to IDLE); en_input=1 one cycle -> RENEW
//   RENEW    nu_en_renew=1 one cycle -> DIVIDE
//   DIVIDE   nu_en_divide=1 one cycle; wait counter cleared -> WAIT_DIV
//   WAIT_DIV counter++ each cycle; nu_divider_flag ignored on first WAIT_DIV cycle (stale flag);
//            flag=1 on cycle>=2 -> capture nu_dist/nu_norm_dist -> RESULT;
//            counter==DIV_TMO -> capture anyway, set tmo_err -> RESULT
//   RESULT   res_valid=1, res_* stable; on res_ready -> IDLE, smp_count++ (wraps), res_valid=0 next cycle
//  Latency: smp accept at edge N -> en_input N+1, en_renew N+2, en_divide N+3, res_valid >= N+6.
//  Exactly one strobe of en_input/en_renew/en_divide/ini_para high in any cycle; never overlap.
//  No new request accepted until RESULT handshake completes (single outstanding op).
//  Reset mid-operation: strobes drop immediately (async), latched data lost, no result produced.
//  res_ready held high before res_valid: handshake completes the first RESULT cycle (1-cycle RESULT).
// TESTING
//  1 Reset: hold rst=0 mid-WAIT_DIV -> all strobes 0 asynchronously, cfg_ready=smp_ready=1 after release.
//  2 cfg mu=8192 sigma2=16384 -> nu_ini_para high exactly 2 cycles with those operands, then 0s, back to IDLE.
//  3 smp data=0 learn=1, model flag after 14 cycles -> strobes at N+1/N+2/N+3 one cycle each,
//    renew_flag=1 throughout, res_dist/res_norm_dist equal model values, smp_count=1.
//  4 smp data=3277 learn=0, res_ready low 5 cycles -> res_valid and res_* stable 5 cycles, then IDLE.
//  5 cfg_valid and smp_valid same cycle -> INIT runs first, sample accepted on first IDLE cycle after.
//  6 flag never asserted -> RESULT after DIV_TMO=32 WAIT_DIV cycles, tmo_err=1 and stays 1; smp_count
//    preloaded 0xFFFF wraps to 0.

Source files
------------

// File: rtl/neuronunit_seq.sv
// Sequencer for a single neuronunit: accepts parameter loads and samples over
// valid/ready, steps the unit through ini_para / en_input / en_renew / en_divide,
// waits for the divider and hands dist/norm_dist back over a valid/ready port.
module neuronunit_seq #(
    parameter int DW       = 16,
    parameter int INIT_CYC = 2,
    parameter int DIV_TMO  = 32,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    input  logic signed [DW-1:0] cfg_mu,
    input  logic signed [DW-1:0] cfg_sigma2,
    output logic                 cfg_ready,
    input  logic                 smp_valid,
    input  logic signed [DW-1:0] smp_data,
    input  logic                 smp_learn,
    output logic                 smp_ready,
    output logic                 res_valid,
    output logic signed [DW-1:0] res_dist,
    output logic signed [DW-1:0] res_norm_dist,
    input  logic                 res_ready,
    output logic                 busy,
    output logic                 tmo_err,
    output logic [CNT_W-1:0]     smp_count,
    output logic signed [DW-1:0] nu_in,
    output logic signed [DW-1:0] nu_mu_ini,
    output logic signed [DW-1:0] nu_sigma2_ini,
    output logic                 nu_ini_para,
    output logic                 nu_en_input,
    output logic                 nu_en_renew,
    output logic                 nu_en_divide,
    output logic                 nu_renew_flag,
    input  logic signed [DW-1:0] nu_dist,
    input  logic signed [DW-1:0] nu_norm_dist,
    input  logic                 nu_divider_flag
);

    localparam int IC_W = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
    localparam int WC_W = $clog2(DIV_TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_RENEW,
        S_DIVIDE,
        S_WAIT_DIV,
        S_RESULT
    } state_t;

    state_t          state;
    logic [IC_W-1:0] init_cnt;
    logic [WC_W-1:0] wait_cnt;

    // Control FSM; every output is a register updated together with the state
    // so strobes line up exactly with the state that owns them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            init_cnt      <= '0;
            wait_cnt      <= '0;
            cfg_ready     <= 1'b1;
            smp_ready     <= 1'b1;
            busy          <= 1'b0;
            res_valid     <= 1'b0;
            res_dist      <= '0;
            res_norm_dist <= '0;
            tmo_err       <= 1'b0;
            smp_count     <= '0;
            nu_in         <= '0;
            nu_mu_ini     <= '0;
            nu_sigma2_ini <= '0;
            nu_ini_para   <= 1'b0;
            nu_en_input   <= 1'b0;
            nu_en_renew   <= 1'b0;
            nu_en_divide  <= 1'b0;
            nu_renew_flag <= 1'b0;
        end else begin
            // single-cycle strobes fall back unless a state below re-raises them
            nu_en_input  <= 1'b0;
            nu_en_renew  <= 1'b0;
            nu_en_divide <= 1'b0;
            case (state)
                S_IDLE: begin
                    // ready is high throughout IDLE, so valid alone means accept;
                    // a load request takes priority and the sample stays pending
                    if (cfg_valid) begin
                        state         <= S_INIT;
                        init_cnt      <= '0;
                        nu_ini_para   <= 1'b1;
                        nu_mu_ini     <= cfg_mu;
                        nu_sigma2_ini <= cfg_sigma2;
                        cfg_ready     <= 1'b0;
                        smp_ready     <= 1'b0;
                        busy          <= 1'b1;
                    end else if (smp_valid) begin
                        state         <= S_LOAD;
                        nu_in         <= smp_data;
                        nu_renew_flag <= smp_learn;
                        nu_en_input   <= 1'b1;
                        cfg_ready     <= 1'b0;
                        smp_ready     <= 1'b0;
                        busy          <= 1'b1;
                    end
                end
                S_INIT: begin
                    if (init_cnt == IC_W'(INIT_CYC - 1)) begin
                        state         <= S_IDLE;
                        nu_ini_para   <= 1'b0;
                        nu_mu_ini     <= '0;
                        nu_sigma2_ini <= '0;
                        cfg_ready     <= 1'b1;
                        smp_ready     <= 1'b1;
                        busy          <= 1'b0;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    state       <= S_RENEW;
                    nu_en_renew <= 1'b1;
                end
                S_RENEW: begin
                    state        <= S_DIVIDE;
                    nu_en_divide <= 1'b1;
                end
                S_DIVIDE: begin
                    state    <= S_WAIT_DIV;
                    wait_cnt <= '0;
                end
                S_WAIT_DIV: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // the flag may still be high from the previous divide during
                    // the first wait cycle, so it only counts from the second on
                    if (nu_divider_flag && (wait_cnt != '0)) begin
                        state         <= S_RESULT;
                        res_valid     <= 1'b1;
                        res_dist      <= nu_dist;
                        res_norm_dist <= nu_norm_dist;
                    end else if (wait_cnt == WC_W'(DIV_TMO - 1)) begin
                        state         <= S_RESULT;
                        res_valid     <= 1'b1;
                        res_dist      <= nu_dist;
                        res_norm_dist <= nu_norm_dist;
                        tmo_err       <= 1'b1;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        state         <= S_IDLE;
                        res_valid     <= 1'b0;
                        nu_renew_flag <= 1'b0;
                        smp_count     <= smp_count + 1'b1;
                        cfg_ready     <= 1'b1;
                        smp_ready     <= 1'b1;
                        busy          <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cfg_ready <= 1'b1;
                    smp_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuronunit_seq.sv
// Directed bench for neuronunit_seq with a small behavioural divider model.
module tb_neuronunit_seq;

    localparam int DW    = 16;
    localparam int CNT_W = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_valid, smp_valid, smp_learn, res_ready;
    logic signed [DW-1:0] cfg_mu, cfg_sigma2, smp_data;
    logic                 cfg_ready, smp_ready, res_valid, busy, tmo_err;
    logic signed [DW-1:0] res_dist, res_norm_dist;
    logic [CNT_W-1:0]     smp_count;
    logic signed [DW-1:0] nu_in, nu_mu_ini, nu_sigma2_ini;
    logic                 nu_ini_para, nu_en_input, nu_en_renew, nu_en_divide, nu_renew_flag;
    logic signed [DW-1:0] nu_dist, nu_norm_dist;
    logic                 nu_divider_flag;

    int n_tests = 0;
    int n_fail  = 0;

    // divider model controls
    int                   div_lat;
    logic signed [DW-1:0] m_dist, m_norm;
    int                   div_cnt;
    logic                 div_run;

    logic [3:0] strb;
    assign strb = {nu_ini_para, nu_en_input, nu_en_renew, nu_en_divide};

    neuronunit_seq #(.DW(DW), .INIT_CYC(2), .DIV_TMO(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_mu(cfg_mu), .cfg_sigma2(cfg_sigma2), .cfg_ready(cfg_ready),
        .smp_valid(smp_valid), .smp_data(smp_data), .smp_learn(smp_learn), .smp_ready(smp_ready),
        .res_valid(res_valid), .res_dist(res_dist), .res_norm_dist(res_norm_dist), .res_ready(res_ready),
        .busy(busy), .tmo_err(tmo_err), .smp_count(smp_count),
        .nu_in(nu_in), .nu_mu_ini(nu_mu_ini), .nu_sigma2_ini(nu_sigma2_ini),
        .nu_ini_para(nu_ini_para), .nu_en_input(nu_en_input), .nu_en_renew(nu_en_renew),
        .nu_en_divide(nu_en_divide), .nu_renew_flag(nu_renew_flag),
        .nu_dist(nu_dist), .nu_norm_dist(nu_norm_dist), .nu_divider_flag(nu_divider_flag)
    );

    always #5 clk = ~clk;

    // Divider model: flag level drops one cycle after en_divide is seen and
    // rises (with fresh results) div_lat cycles after it; div_lat=0 never finishes.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            nu_divider_flag <= 1'b1;
            nu_dist         <= 16'sh1111;
            nu_norm_dist    <= 16'sh2222;
            div_run         <= 1'b0;
            div_cnt         <= 0;
        end else if (nu_en_divide) begin
            div_run <= 1'b1;
            div_cnt <= 0;
        end else if (div_run) begin
            div_cnt <= div_cnt + 1;
            if (div_cnt == 0) nu_divider_flag <= 1'b0;
            if (div_lat != 0 && div_cnt + 1 == div_lat) begin
                nu_divider_flag <= 1'b1;
                nu_dist         <= m_dist;
                nu_norm_dist    <= m_norm;
                div_run         <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Waits for res_valid counting negedges; idx is the current negedge index
    // relative to the accept edge (negedge right after it is 1).
    task automatic wait_res(inout int idx);
        while (!res_valid && idx < 200) begin
            @(negedge clk);
            idx++;
        end
    endtask

    // Full sample transaction from IDLE with res_ready held high.
    task automatic do_sample(input logic signed [DW-1:0] d, input logic l,
                             input logic signed [DW-1:0] ed, input logic signed [DW-1:0] en,
                             input int lat, input int exp_idx, input string tag);
        int idx;
        m_dist    = ed;
        m_norm    = en;
        div_lat   = lat;
        res_ready = 1'b1;
        smp_valid = 1'b1;
        smp_data  = d;
        smp_learn = l;
        @(negedge clk);
        smp_valid = 1'b0;
        idx = 1;
        wait_res(idx);
        chk({tag, "_lat"}, idx, exp_idx);
        chk({tag, "_dist"}, res_dist, ed);
        chk({tag, "_norm"}, res_norm_dist, en);
        @(negedge clk);
        chk({tag, "_done"}, res_valid, 0);
    endtask

    initial begin
        int idx;
        int bad;
        rst = 1'b0;
        cfg_valid = 0; smp_valid = 0; smp_learn = 0; res_ready = 0;
        cfg_mu = 0; cfg_sigma2 = 0; smp_data = 0;
        div_lat = 14; m_dist = 0; m_norm = 0;
        repeat (3) @(negedge clk);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_smp_ready", smp_ready, 1);
        chk("rst_strobes", strb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_count", smp_count, 0);
        chk("rst_tmo", tmo_err, 0);
        rst = 1'b1;
        @(negedge clk);

        // parameter load: ini_para two cycles with operands, then zeroed
        cfg_valid = 1; cfg_mu = 8192; cfg_sigma2 = 16384;
        @(negedge clk);
        cfg_valid = 0;
        chk("t2_strb0", strb, 4'b1000);
        chk("t2_mu0", nu_mu_ini, 8192);
        chk("t2_sig0", nu_sigma2_ini, 16384);
        chk("t2_cfg_ready0", cfg_ready, 0);
        @(negedge clk);
        chk("t2_strb1", strb, 4'b1000);
        chk("t2_mu1", nu_mu_ini, 8192);
        @(negedge clk);
        chk("t2_strb2", strb, 4'b0000);
        chk("t2_mu2", nu_mu_ini, 0);
        chk("t2_sig2", nu_sigma2_ini, 0);
        chk("t2_idle", cfg_ready, 1);
        chk("t2_busy", busy, 0);

        // learning sample, stale flag on first wait cycle, 1-cycle RESULT
        m_dist = -8192; m_norm = -4096; div_lat = 14; res_ready = 1;
        smp_valid = 1; smp_data = 0; smp_learn = 1;
        @(negedge clk);
        smp_valid = 0;
        chk("t3_en_input", strb, 4'b0100);
        chk("t3_flag", nu_renew_flag, 1);
        chk("t3_smp_ready", smp_ready, 0);
        @(negedge clk);
        chk("t3_en_renew", strb, 4'b0010);
        @(negedge clk);
        chk("t3_en_divide", strb, 4'b0001);
        idx = 3; bad = 0;
        while (!res_valid && idx < 200) begin
            @(negedge clk);
            idx++;
            if (strb != 0 || nu_renew_flag != 1) bad++;
        end
        chk("t3_quiet", bad, 0);
        chk("t3_lat", idx, 19);
        chk("t3_dist", res_dist, -8192);
        chk("t3_norm", res_norm_dist, -4096);
        @(negedge clk);
        chk("t3_res_drop", res_valid, 0);
        chk("t3_count", smp_count, 1);
        chk("t3_flag_clr", nu_renew_flag, 0);

        // distance-only sample with consumer stalling 5 cycles
        m_dist = -4915; m_norm = -2458; res_ready = 0;
        smp_valid = 1; smp_data = 3277; smp_learn = 0;
        @(negedge clk);
        smp_valid = 0;
        chk("t4_nu_in", nu_in, 3277);
        chk("t4_flag", nu_renew_flag, 0);
        idx = 1;
        wait_res(idx);
        chk("t4_lat", idx, 19);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!res_valid || res_dist != -4915 || res_norm_dist != -2458 || smp_ready) bad++;
        end
        chk("t4_hold", bad, 0);
        res_ready = 1;
        @(negedge clk);
        chk("t4_res_drop", res_valid, 0);
        chk("t4_busy", busy, 0);
        chk("t4_count", smp_count, 2);
        chk("t4_nu_in_held", nu_in, 3277);

        // simultaneous cfg and smp: INIT first, sample on first IDLE cycle after
        m_dist = 100; m_norm = 50;
        cfg_valid = 1; cfg_mu = 4096; cfg_sigma2 = 2048;
        smp_valid = 1; smp_data = -1000; smp_learn = 1;
        @(negedge clk);
        cfg_valid = 0;
        chk("t5_init", strb, 4'b1000);
        chk("t5_smp_ready", smp_ready, 0);
        chk("t5_mu", nu_mu_ini, 4096);
        @(negedge clk);
        chk("t5_init2", strb, 4'b1000);
        @(negedge clk);
        chk("t5_idle", strb, 4'b0000);
        chk("t5_idle_ready", smp_ready, 1);
        @(negedge clk);
        smp_valid = 0;
        chk("t5_en_input", strb, 4'b0100);
        chk("t5_nu_in", nu_in, -1000);
        idx = 1;
        wait_res(idx);
        chk("t5_lat", idx, 19);
        chk("t5_dist", res_dist, 100);
        @(negedge clk);
        chk("t5_count", smp_count, 3);

        // reset in the middle of WAIT_DIV
        m_dist = 7; m_norm = 3;
        smp_valid = 1; smp_data = 500; smp_learn = 1;
        @(negedge clk);
        smp_valid = 0;
        repeat (4) @(negedge clk);
        chk("t1_busy_pre", busy, 1);
        #1 rst = 1'b0;
        #1;
        chk("t1_async_strb", strb, 0);
        chk("t1_async_busy", busy, 0);
        chk("t1_async_flag", nu_renew_flag, 0);
        chk("t1_async_nu_in", nu_in, 0);
        chk("t1_async_count", smp_count, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t1_cfg_ready", cfg_ready, 1);
        chk("t1_smp_ready", smp_ready, 1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid || busy) bad++;
        end
        chk("t1_no_result", bad, 0);

        // timeout and counter wrap
        chk("t6_tmo_pre", tmo_err, 0);
        for (int i = 0; i < 15; i++)
            do_sample(16'(i * 100), 1'b0, 16'(i), 16'(-i), 14, 19, "t6_fill");
        chk("t6_count15", smp_count, 15);
        do_sample(1234, 1'b1, 14, -14, 0, 36, "t6_tmo");
        chk("t6_tmo_set", tmo_err, 1);
        chk("t6_wrap", smp_count, 0);
        do_sample(5, 1'b0, 42, 21, 14, 19, "t6_after");
        chk("t6_tmo_sticky", tmo_err, 1);
        chk("t6_count1", smp_count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
